// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, ALU op encodings,
// FSM state encoding and small key-decode helpers.
package calc_pkg;

  // Key codes (0-9 are digits)
  localparam logic [3:0] KeyAdd = 4'hA;
  localparam logic [3:0] KeySub = 4'hB;
  localparam logic [3:0] KeyMul = 4'hC;
  localparam logic [3:0] KeyDiv = 4'hD;
  localparam logic [3:0] KeyEq  = 4'hE;
  localparam logic [3:0] KeyClr = 4'hF;

  // ALU operation encodings
  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t StEnterA = 3'd0;
  localparam state_t StEnterB = 3'd1;
  localparam state_t StCalc   = 3'd2;
  localparam state_t StResult = 3'd3;
  localparam state_t StError  = 3'd4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KeyAdd) && (k <= KeyDiv);
  endfunction

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [1:0] op;
    case (k)
      KeySub:  op = OpSub;
      KeyMul:  op = OpMul;
      KeyDiv:  op = OpDiv;
      default: op = OpAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// Decimal operand accumulator: value = value*10 + digit, saturating at
// MAX_DIGITS entered digits (further digits are dropped).
module calc_operand_acc #(
  parameter int unsigned W          = 10,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,    // zero value and digit count
  input  logic         load_i,   // start a fresh operand holding digit_i
  input  logic         push_i,   // append digit_i if room remains
  input  logic [3:0]   digit_i,
  output logic [W-1:0] value_o,
  output logic         empty_o   // no digits entered yet
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  logic [W-1:0]    value_q, value_d;
  logic [CntW-1:0] count_q, count_d;

  // Next-state: clear beats load beats append
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr_i) begin
      value_d = '0;
      count_d = '0;
    end else if (load_i) begin
      value_d = W'(digit_i);
      count_d = CntW'(1);
    end else if (push_i && (count_q < CntW'(MAX_DIGITS))) begin
      value_d = (value_q * W'(10)) + W'(digit_i);
      count_d = count_q + CntW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects two decimal operands and an operator from
// key strobes, hands them to an external ALU and shows operands/result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned W          = 10,
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  input  logic [3:0]     key_code,
  output logic           alu_start,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result,
  input  logic           alu_err,
  output logic [2*W-1:0] disp_value,
  output logic           disp_err,
  output logic           busy
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic [2*W-1:0]   result_q, result_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic key_dig, key_op, key_eq, key_clr;
  logic a_clr, a_load, a_push, b_clr, b_push;
  logic a_empty, b_empty;
  logic [W-1:0] a_val, b_val;

  assign key_dig = key_valid && is_digit(key_code);
  assign key_op  = key_valid && is_op(key_code);
  assign key_eq  = key_valid && (key_code == KeyEq);
  assign key_clr = key_valid && (key_code == KeyClr);

  calc_operand_acc #(
    .W          (W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (a_clr),
    .load_i  (a_load),
    .push_i  (a_push),
    .digit_i (key_code),
    .value_o (a_val),
    .empty_o (a_empty)
  );

  calc_operand_acc #(
    .W          (W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (b_clr),
    .load_i  (1'b0),
    .push_i  (b_push),
    .digit_i (key_code),
    .value_o (b_val),
    .empty_o (b_empty)
  );

  // FSM next-state and operand control; clear overrides every state
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    start_d  = 1'b0;
    result_d = result_q;
    wait_d   = wait_q;
    a_clr    = 1'b0;
    a_load   = 1'b0;
    a_push   = 1'b0;
    b_clr    = 1'b0;
    b_push   = 1'b0;
    if (key_clr) begin
      state_d  = StEnterA;
      op_d     = OpAdd;
      result_d = '0;
      wait_d   = '0;
      a_clr    = 1'b1;
      b_clr    = 1'b1;
    end else begin
      case (state_q)
        StEnterA: begin
          if (key_dig) begin
            a_push = 1'b1;
          end else if (key_op) begin
            op_d    = key_to_op(key_code);
            a_clr   = a_empty;  // no digits means A reads as 0
            b_clr   = 1'b1;
            state_d = StEnterB;
          end
        end
        StEnterB: begin
          if (key_dig) begin
            b_push = 1'b1;
          end else if (key_op && b_empty) begin
            op_d = key_to_op(key_code);
          end else if (key_eq && !b_empty) begin
            state_d = StCalc;
            start_d = 1'b1;
            wait_d  = '0;
          end
        end
        StCalc: begin
          if (alu_done) begin
            if (alu_err) begin
              result_d = '0;
              state_d  = StError;
            end else begin
              result_d = alu_result;
              state_d  = StResult;
            end
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            state_d = StError;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        StResult: begin
          if (key_dig) begin
            a_load  = 1'b1;
            b_clr   = 1'b1;
            state_d = StEnterA;
          end
        end
        StError: ;
        default: state_d = StEnterA;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEnterA;
      op_q     <= OpAdd;
      start_q  <= 1'b0;
      result_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      start_q  <= start_d;
      result_q <= result_d;
      wait_q   <= wait_d;
    end
  end

  // Display mux; in CALC both operands are shown side by side as {A, B}
  always_comb begin
    case (state_q)
      StEnterA: disp_value = {{W{1'b0}}, a_val};
      StEnterB: disp_value = {{W{1'b0}}, b_val};
      StCalc:   disp_value = {a_val, b_val};
      StResult: disp_value = result_q;
      default:  disp_value = '0;
    endcase
  end

  assign alu_start = start_q;
  assign alu_op    = op_q;
  assign alu_a     = a_val;
  assign alu_b     = b_val;
  assign disp_err  = (state_q == StError);
  assign busy      = (state_q == StCalc);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios followed by
// random key streams, all checked against a key-level behavioural model.
module tb_calc_sequencer;

  localparam int W       = 10;
  localparam int RW      = 2 * W;
  localparam int TIMEOUT = 1024;

  // Model state names
  localparam int MEnterA = 0;
  localparam int MEnterB = 1;
  localparam int MCalc   = 2;
  localparam int MResult = 3;
  localparam int MError  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          alu_start;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic          alu_done;
  logic [RW-1:0] alu_result;
  logic          alu_err;
  logic [RW-1:0] disp_value;
  logic          disp_err;
  logic          busy;

  calc_sequencer #(
    .W          (W),
    .MAX_DIGITS (3),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  // Model: calculator as seen from the keypad
  int m_state, m_a, m_b, m_ca, m_cb, m_op;
  longint m_res;

  // Count alu_start pulses shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (alu_start === 1'b1) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MEnterA;
    m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 0; m_res = 0;
  endtask

  // Apply one key press; go reports that a calculation was launched
  task automatic model_key(input int k, output bit go);
    go = 1'b0;
    if (k == 15) begin
      model_reset();
    end else begin
      case (m_state)
        MEnterA: begin
          if (k <= 9) begin
            if (m_ca < 3) begin m_a = m_a * 10 + k; m_ca++; end
          end else if (k <= 13) begin
            m_op = k - 10; m_b = 0; m_cb = 0; m_state = MEnterB;
          end
        end
        MEnterB: begin
          if (k <= 9) begin
            if (m_cb < 3) begin m_b = m_b * 10 + k; m_cb++; end
          end else if (k <= 13) begin
            if (m_cb == 0) m_op = k - 10;
          end else if (k == 14 && m_cb > 0) begin
            m_state = MCalc; go = 1'b1;
          end
        end
        MResult: begin
          if (k <= 9) begin
            m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_state = MEnterA;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [63:0] exp_disp();
    case (m_state)
      MEnterA: return 64'(m_a);
      MEnterB: return 64'(m_b);
      MCalc:   return 64'(m_a * (1 << W) + m_b);
      MResult: return 64'(m_res);
      default: return 64'd0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, " disp_value"}, 64'(disp_value), exp_disp());
    check({tag, " disp_err"}, 64'(disp_err), 64'(m_state == MError));
    check({tag, " busy"}, 64'(busy), 64'(m_state == MCalc));
  endtask

  task automatic press(input int k);
    int s0;
    bit go;
    s0 = start_cnt;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
    model_key(k, go);
    check_outputs($sformatf("key %0h", k));
    check("alu_start pulses", 64'(start_cnt - s0), 64'(go));
    if (go) begin
      check("alu_op", 64'(alu_op), 64'(m_op));
      check("alu_a", 64'(alu_a), 64'(m_a));
      check("alu_b", 64'(alu_b), 64'(m_b));
    end
  endtask

  task automatic keys(input string seq);
    for (int i = 0; i < seq.len(); i++) begin
      byte c;
      c = seq[i];
      press((c >= "A") ? int'(c - "A") + 10 : int'(c - "0"));
    end
  endtask

  task automatic done(input logic [RW-1:0] res, input bit err);
    int s0;
    s0 = start_cnt;
    @(negedge clk);
    alu_done   = 1'b1;
    alu_result = res;
    alu_err    = err;
    @(negedge clk);
    alu_done = 1'b0;
    alu_err  = 1'b0;
    if (m_state == MCalc) begin
      if (err) m_state = MError;
      else begin m_state = MResult; m_res = longint'(res); end
    end
    check_outputs("alu_done");
    check("alu_start after done", 64'(start_cnt - s0), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst alu_start", 64'(alu_start), 64'd0);
    check("rst alu_op", 64'(alu_op), 64'd0);
    check("rst alu_a", 64'(alu_a), 64'd0);
    check("rst alu_b", 64'(alu_b), 64'd0);
    check("rst disp_value", 64'(disp_value), 64'd0);
    check("rst disp_err", 64'(disp_err), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    alu_done   = 1'b0;
    alu_result = '0;
    alu_err    = 1'b0;
    model_reset();
    do_reset();

    // 12 + 3 = 15
    keys("12A3E");
    repeat (3) @(negedge clk);
    check_outputs("calc wait");
    done(RW'(15), 1'b0);
    check("add result", 64'(disp_value), 64'd15);

    // Fourth digit dropped, equals ignored in ENTER_A
    keys("F1234");
    check("saturated A", 64'(disp_value), 64'd123);
    keys("E");

    // Divide by zero reported by the ALU
    keys("F8D0E");
    done(RW'(0), 1'b1);
    check("div0 disp_err", 64'(disp_err), 64'd1);
    keys("5F");
    check("clear after error", 64'(disp_value), 64'd0);

    // ALU never answers: timeout lands exactly after TIMEOUT cycles in CALC
    keys("F5C6E");
    repeat (TIMEOUT - 1) @(negedge clk);
    check("busy last calc cycle", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy after timeout", 64'(busy), 64'd0);
    check("err after timeout", 64'(disp_err), 64'd1);
    m_state = MError;
    done(RW'(30), 1'b0);

    // Clear during CALC, late result ignored
    keys("F4A4E");
    repeat (2) @(negedge clk);
    keys("F");
    done(RW'(99), 1'b0);
    check("late done ignored", 64'(disp_value), 64'd0);

    // Reset mid-entry, then equals in ENTER_A does nothing
    keys("F7B");
    do_reset();
    keys("9E");

    // Reset during CALC, then a stale completion
    keys("F2C2E");
    do_reset();
    done(RW'(4), 1'b0);
    check("stale done after reset", 64'(disp_value), 64'd0);

    // Random key streams with random ALU behaviour
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      if (k == 15 && $urandom_range(0, 3) != 0) k = 14;
      if (m_state == MError && $urandom_range(0, 3) == 0) k = 15;
      press(k);
      if (m_state == MCalc) begin
        int r;
        r = int'($urandom_range(0, 7));
        repeat ($urandom_range(0, 8)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) press(int'($urandom_range(0, 14)));
        if (r == 0) begin
          press(15);
          done(RW'($urandom), 1'b0);
        end else begin
          done(RW'($urandom), r == 1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
